add_arbiter: RTL

ADD_ARBITER -- requirements
Module: add_arbiter

---
 rtl/add_arbiter_if.sv | 27 ++
 rtl/add_arbiter.sv | 120 ++++++++++++
 2 files changed

// File: rtl/add_arbiter_if.sv
// Bundles the request/operand/ack inputs and the grant/result outputs of add_arbiter.
// The DUT uses the slave view; a requester/consumer model uses the master view.
interface add_arbiter_if #(
  parameter int W = 8,
  parameter int N = 4
);
  logic [N-1:0]   req;
  logic [N*W-1:0] a_in;
  logic [N*W-1:0] b_in;
  logic           ack;
  logic [N-1:0]   gnt;
  logic           busy;
  logic [W-1:0]   sum;
  logic           carry;
  logic           sum_valid;
  logic [1:0]     sum_id;

  modport master (
    output req, a_in, b_in, ack,
    input  gnt, busy, sum, carry, sum_valid, sum_id
  );

  modport slave (
    input  req, a_in, b_in, ack,
    output gnt, busy, sum, carry, sum_valid, sum_id
  );
endinterface

// File: rtl/add_arbiter.sv
// One W-bit adder shared by four requesters through a round-robin arbiter.
// Each operation walks IDLE -> LOAD -> EXEC -> RESP; every output is a flop.
module add_arbiter #(
  parameter int W = 8,
  parameter int N = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  add_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, LOAD, EXEC, RESP} state_t;

  state_t         state_q, state_d;
  logic [1:0]     win_q, win_d;
  logic [1:0]     last_id_q, last_id_d;
  logic [W-1:0]   op_a_q, op_a_d;
  logic [W-1:0]   op_b_q, op_b_d;
  logic [W-1:0]   sum_q, sum_d;
  logic           carry_q, carry_d;
  logic [1:0]     sum_id_q, sum_id_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic           busy_q, busy_d;
  logic           sum_valid_q, sum_valid_d;
  logic [1:0]     pick;
  logic [1:0]     rr_idx;
  logic           found;

  // Round-robin search starts just above the last served requester; 2-bit wrap gives 3 -> 0.
  always_comb begin
    pick   = last_id_q;
    found  = 1'b0;
    rr_idx = last_id_q;
    for (int k = 1; k <= 4; k++) begin
      rr_idx = last_id_q + 2'(k);
      if (!found && bus.req[rr_idx]) begin
        pick  = rr_idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    last_id_d = last_id_q;
    op_a_d    = op_a_q;
    op_b_d    = op_b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    sum_id_d  = sum_id_q;

    case (state_q)
      IDLE: begin
        if (|bus.req) begin
          win_d   = pick;
          state_d = LOAD;
        end
      end
      LOAD: begin
        op_a_d  = bus.a_in[int'(win_q)*W +: W];
        op_b_d  = bus.b_in[int'(win_q)*W +: W];
        state_d = EXEC;
      end
      EXEC: begin
        {carry_d, sum_d} = {1'b0, op_a_q} + {1'b0, op_b_q};
        sum_id_d         = win_q;
        state_d          = RESP;
      end
      RESP: begin
        if (bus.ack) begin
          last_id_d = win_q;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Status outputs are decoded from the next state so they line up with it once registered.
    gnt_d       = (state_d == LOAD) ? (N'(1) << win_d) : '0;
    busy_d      = (state_d != IDLE);
    sum_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      win_q       <= '0;
      last_id_q   <= 2'd3;
      op_a_q      <= '0;
      op_b_q      <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      sum_id_q    <= '0;
      gnt_q       <= '0;
      busy_q      <= 1'b0;
      sum_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      win_q       <= win_d;
      last_id_q   <= last_id_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      sum_id_q    <= sum_id_d;
      gnt_q       <= gnt_d;
      busy_q      <= busy_d;
      sum_valid_q <= sum_valid_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.busy      = busy_q;
  assign bus.sum       = sum_q;
  assign bus.carry     = carry_q;
  assign bus.sum_valid = sum_valid_q;
  assign bus.sum_id    = sum_id_q;

endmodule
